// File: rtl/mem_arbiter.sv
// Round-robin arbiter: N_REQ line requesters onto one memory port, one transaction in flight, response routed by ID.
// Latency: request -> o_mem_enable 1 cycle; memory response -> o_resp_valid 1 cycle; WAIT times out after TIMEOUT cycles.
module mem_arbiter #(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 256,
  parameter int ID_WIDTH   = 2,
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_write,
  input  logic [N_REQ*PA_WIDTH-1:0]   i_req_addr,
  input  logic [N_REQ*LINE_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [N_REQ-1:0]            o_resp_valid,
  output logic [LINE_WIDTH-1:0]       o_resp_data,
  output logic                        o_resp_error,
  output logic                        o_mem_enable,
  output logic                        o_mem_write,
  output logic [PA_WIDTH-1:0]         o_mem_addr,
  output logic [LINE_WIDTH-1:0]       o_mem_data,
  output logic [ID_WIDTH-1:0]         o_mem_id,
  input  logic                        i_mem_enable,
  input  logic [LINE_WIDTH-1:0]       i_mem_data,
  input  logic [ID_WIDTH-1:0]         i_mem_id_response
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;

  logic [N_REQ-1:0]      req_ready_q, req_ready_d;
  logic [N_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_error_q, resp_error_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [PA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ID_WIDTH-1:0]   mem_id_q, mem_id_d;

  logic [2*N_REQ-1:0]    vld_rot;
  logic                  found;
  logic [ID_WIDTH-1:0]   pick;
  int                    pick_int;
  logic                  sel_write;
  logic [PA_WIDTH-1:0]   sel_addr;
  logic [LINE_WIDTH-1:0] sel_data;
  logic                  rsp_match;

  // Rotate the doubled valid vector so bit 0 is rr_ptr; scanning downwards leaves the lowest set offset.
  always_comb begin
    vld_rot  = {i_req_valid, i_req_valid} >> rr_ptr_q;
    found    = 1'b0;
    pick_int = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vld_rot[i]) begin
        found    = 1'b1;
        pick_int = int'(rr_ptr_q) + i;
        if (pick_int >= N_REQ) pick_int = pick_int - N_REQ;
      end
    end
    pick = ID_WIDTH'(pick_int);
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == ID_WIDTH'(i)) begin
        sel_write = i_req_write[i];
        sel_addr  = i_req_addr[i*PA_WIDTH +: PA_WIDTH];
        sel_data  = i_req_data[i*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  assign rsp_match = i_mem_enable && (i_mem_id_response == gnt_q);

  // Every output register defaults to zero, so all strobes are single-cycle pulses.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;
    mem_enable_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_data_d   = '0;
    mem_id_d     = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d        = pick;
          write_d      = sel_write;
          rr_ptr_d     = (pick_int == N_REQ - 1) ? '0 : pick + 1'b1;
          req_ready_d  = N_REQ'(1) << pick;
          mem_enable_d = 1'b1;
          mem_write_d  = sel_write;
          mem_addr_d   = sel_addr;
          mem_data_d   = sel_data;
          mem_id_d     = pick;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A matching response in the final WAIT cycle takes priority over the timeout.
        if (rsp_match) begin
          resp_valid_d = N_REQ'(1) << gnt_q;
          resp_data_d  = write_q ? '0 : i_mem_data;
          state_d      = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_valid_d = N_REQ'(1) << gnt_q;
          resp_error_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_id_q     <= mem_id_d;
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_resp_error = resp_error_q;
  assign o_mem_enable = mem_enable_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_id     = mem_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, round-robin contention, write ack, wrong ID/timeout, race, reset in WAIT.
module tb_mem_arbiter;

  localparam int PA = 32;
  localparam int LW = 256;
  localparam int IW = 2;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   i_req_valid, i_req_write;
  logic [NR*PA-1:0] i_req_addr;
  logic [NR*LW-1:0] i_req_data;
  logic [NR-1:0]   o_req_ready, o_resp_valid;
  logic [LW-1:0]   o_resp_data;
  logic            o_resp_error;
  logic            o_mem_enable, o_mem_write;
  logic [PA-1:0]   o_mem_addr;
  logic [LW-1:0]   o_mem_data;
  logic [IW-1:0]   o_mem_id;
  logic            i_mem_enable;
  logic [LW-1:0]   i_mem_data;
  logic [IW-1:0]   i_mem_id_response;

  int vectors = 0;
  int miscompares = 0;
  int n_enable = 0;
  logic early;

  always #5 clk = ~clk;

  mem_arbiter #(.PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW), .N_REQ(NR), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid),
    .o_resp_data(o_resp_data), .o_resp_error(o_resp_error),
    .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_id(o_mem_id),
    .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data),
    .i_mem_id_response(i_mem_id_response)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_mem_enable) n_enable++;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_rsp(input logic [IW-1:0] id, input logic [LW-1:0] data);
    i_mem_enable      = 1'b1;
    i_mem_id_response = id;
    i_mem_data        = data;
  endtask

  task automatic mem_idle();
    i_mem_enable      = 1'b0;
    i_mem_id_response = '0;
    i_mem_data        = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] pat;
    logic [NR-1:0] onehot;
    int g;

    rst = 1'b1;
    i_req_valid = '0; i_req_write = '0; i_req_addr = '0; i_req_data = '0;
    mem_idle();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_mem_enable", LW'(o_mem_enable), '0);
    chk("rst_req_ready",  LW'(o_req_ready), '0);
    chk("rst_resp_valid", LW'(o_resp_valid), '0);
    chk("rst_resp_data",  o_resp_data, '0);
    chk("rst_mem_id",     LW'(o_mem_id), '0);

    // Single read from requester 1
    i_req_valid = 4'b0010;
    i_req_addr[1*PA +: PA] = 32'h40;
    tick();
    chk("rd_mem_enable", LW'(o_mem_enable), LW'(1));
    chk("rd_mem_id",     LW'(o_mem_id), LW'(1));
    chk("rd_req_ready",  LW'(o_req_ready), LW'(4'b0010));
    chk("rd_mem_addr",   LW'(o_mem_addr), LW'(32'h40));
    chk("rd_mem_write",  LW'(o_mem_write), '0);
    i_req_valid = '0;
    tick();
    chk("rd_enable_pulse", LW'(o_mem_enable), '0);
    chk("rd_ready_pulse",  LW'(o_req_ready), '0);
    tick();
    mem_rsp(2'd1, {8{32'hA5A5A5A5}});
    tick();
    mem_idle();
    chk("rd_resp_valid", LW'(o_resp_valid), LW'(4'b0010));
    chk("rd_resp_data",  o_resp_data, {8{32'hA5A5A5A5}});
    chk("rd_resp_error", LW'(o_resp_error), '0);
    tick();
    chk("rd_resp_pulse", LW'(o_resp_valid), '0);
    chk("rd_resp_data_idle", o_resp_data, '0);

    // Contention: all requesters valid from reset
    rst = 1'b1;
    i_req_valid = 4'b1111;
    for (int k = 0; k < NR; k++) i_req_addr[k*PA +: PA] = 32'h1000 + 32'h100 * k;
    tick();
    rst = 1'b0;
    n_enable = 0;
    for (int k = 0; k < 5; k++) begin
      g = k % NR;
      onehot = NR'(1) << g;
      pat = {8{32'h11111111 * (g + 1)}};
      tick();
      chk("rr_mem_id",    LW'(o_mem_id), LW'(g));
      chk("rr_req_ready", LW'(o_req_ready), LW'(onehot));
      chk("rr_mem_addr",  LW'(o_mem_addr), LW'(32'h1000 + 32'h100 * g));
      tick();
      mem_rsp(IW'(g), pat);
      tick();
      mem_idle();
      if (k == 4) i_req_valid = '0;
      chk("rr_resp_valid", LW'(o_resp_valid), LW'(onehot));
      chk("rr_resp_data",  o_resp_data, pat);
    end
    tick(); tick();
    chk("rr_enable_count", LW'(n_enable), LW'(5));

    // Write from requester 2
    i_req_valid = 4'b0100;
    i_req_write = 4'b0100;
    i_req_addr[2*PA +: PA] = 32'h80;
    i_req_data[2*LW +: LW] = LW'(16'hDEAD);
    tick();
    chk("wr_mem_enable", LW'(o_mem_enable), LW'(1));
    chk("wr_mem_write",  LW'(o_mem_write), LW'(1));
    chk("wr_mem_data",   o_mem_data, LW'(16'hDEAD));
    chk("wr_mem_addr",   LW'(o_mem_addr), LW'(32'h80));
    chk("wr_mem_id",     LW'(o_mem_id), LW'(2));
    i_req_valid = '0; i_req_write = '0;
    tick();
    mem_rsp(2'd2, {LW{1'b1}});
    tick();
    mem_idle();
    chk("wr_resp_valid", LW'(o_resp_valid), LW'(4'b0100));
    chk("wr_resp_data",  o_resp_data, '0);
    chk("wr_resp_error", LW'(o_resp_error), '0);

    // Wrong ID then timeout for requester 0
    i_req_valid = 4'b0001;
    tick();
    chk("to_mem_id", LW'(o_mem_id), '0);
    i_req_valid = '0;
    early = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      if (c == 2) mem_rsp(2'd3, {8{32'h33333333}});
      if (c == 3) mem_idle();
      tick();
      early = early | (|o_resp_valid);
    end
    chk("to_no_early_resp", LW'(early), '0);
    tick();
    chk("to_resp_valid", LW'(o_resp_valid), LW'(4'b0001));
    chk("to_resp_error", LW'(o_resp_error), LW'(1));
    chk("to_resp_data",  o_resp_data, '0);
    tick();
    chk("to_error_idle", LW'(o_resp_error), '0);

    // Response in the final WAIT cycle, then a duplicate
    i_req_valid = 4'b0010;
    tick();
    chk("race_mem_id", LW'(o_mem_id), LW'(1));
    i_req_valid = '0;
    early = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      early = early | (|o_resp_valid);
    end
    chk("race_no_early_resp", LW'(early), '0);
    mem_rsp(2'd1, {8{32'h5A5A5A5A}});
    tick();
    chk("race_resp_valid", LW'(o_resp_valid), LW'(4'b0010));
    chk("race_resp_error", LW'(o_resp_error), '0);
    chk("race_resp_data",  o_resp_data, {8{32'h5A5A5A5A}});
    tick();
    mem_idle();
    chk("race_dup_dropped", LW'(o_resp_valid), '0);

    // Reset while waiting on requester 1
    i_req_valid = 4'b0010;
    tick();
    chk("rw_mem_id", LW'(o_mem_id), LW'(1));
    i_req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_resp_valid", LW'(o_resp_valid), '0);
    chk("rw_mem_enable", LW'(o_mem_enable), '0);
    chk("rw_resp_data",  o_resp_data, '0);
    mem_rsp(2'd1, {8{32'h77777777}});
    tick();
    mem_idle();
    chk("rw_stale_dropped", LW'(o_resp_valid), '0);
    chk("rw_stale_error",   LW'(o_resp_error), '0);
    i_req_valid = 4'b1010;
    tick();
    chk("rw_regrant_id",    LW'(o_mem_id), LW'(1));
    chk("rw_regrant_ready", LW'(o_req_ready), LW'(4'b0010));
    i_req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
